vga_sync_monitor: RTL

- Receiving end of the 640x480@60 VGA link: consumes hs/vs/RGB as driven to the connector and recovers pixel coordinates and data-enable.
- Checks horizontal and vertical timing against parameters and declares lock after consecutive clean frames.
- Sits beside the VGA output path as an on-chip checker and capture front-end, clocked by vga_clk.

---
 rtl/vga_sync_monitor.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: VGA receive-side timing checker and pixel-coordinate recovery.
// Registers hs/vs/rgb once, tracks line/frame position from the sync edges,
// qualifies line and frame timing, and declares lock after LOCK_FRAMES clean frames.
// Optional macro VGA_SYNC_MONITOR_CHECKSUM_EN adds a per-frame RGB checksum
// (frame_sum / frame_sum_vld).
module vga_sync_monitor #(
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VIS       = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SYNC_POL    = 0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  input  logic        err_clr,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        px_de,
  output logic [11:0] px_rgb,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] frame_cnt
`ifdef VGA_SYNC_MONITOR_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum,
  output logic        frame_sum_vld
`endif
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_OFF = H_SYNC + H_BP;
  localparam int unsigned H_END = H_OFF + H_VIS - 1;
  localparam int unsigned V_OFF = V_SYNC + V_BP;
  localparam int unsigned V_END = V_OFF + V_VIS - 1;
  localparam logic        POL   = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    SYNCING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic        clr_q, clr_d;
  logic [11:0] rgb_q, rgb_d;
  logic [10:0] h_cnt_q, h_cnt_d, hs_w_q, hs_w_d;
  logic [9:0]  v_cnt_q, v_cnt_d, vs_w_q, vs_w_d;
  logic        bad_seen_q, bad_seen_d;
  logic [3:0]  good_q, good_d;
  logic        h_err_q, h_err_d, v_err_q, v_err_d, locked_q, locked_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [9:0]  px_x_q, px_x_d, px_y_q, px_y_d;
  logic        px_de_q, px_de_d;
  logic [11:0] px_rgb_q, px_rgb_d;

  logic hs_edge, vs_edge, line_good, line_bad, vtime_good, frame_good, in_win;

  // Edge detection and line/frame judgement on the registered samples.
  assign hs_edge    = hs_q & ~hs_prev_q;
  assign vs_edge    = vs_q & ~vs_prev_q;
  assign line_good  = (h_cnt_q == 11'(H_TOT - 1)) && (hs_w_q == 11'(H_SYNC));
  assign line_bad   = hs_edge & ~line_good;
  assign vtime_good = (v_cnt_q == 10'(V_TOT - 1)) && (vs_w_q == 10'(V_SYNC));
  assign frame_good = vtime_good & ~bad_seen_q & ~line_bad;

  // Input stage, position counters, lock FSM next state and output values.
  always_comb begin
    hs_d        = hs_in ^ ~POL;
    vs_d        = vs_in ^ ~POL;
    rgb_d       = {r_in, g_in, b_in};
    clr_d       = err_clr;
    hs_prev_d   = hs_q;
    vs_prev_d   = vs_q;
    state_d     = state_q;
    good_d      = good_q;
    h_err_d     = h_err_q & ~clr_q;
    v_err_d     = v_err_q & ~clr_q;
    frame_cnt_d = frame_cnt_q;

    // h_cnt_d / v_cnt_d are the coordinates of the sample now in rgb_q.
    if (hs_edge)                h_cnt_d = '0;
    else if (h_cnt_q == '1)     h_cnt_d = h_cnt_q;
    else                        h_cnt_d = h_cnt_q + 11'd1;

    if (hs_edge)                hs_w_d = 11'd1;
    else if (hs_q && hs_w_q != '1) hs_w_d = hs_w_q + 11'd1;
    else                        hs_w_d = hs_w_q;

    if (vs_edge)                      v_cnt_d = '0;
    else if (hs_edge && v_cnt_q != '1) v_cnt_d = v_cnt_q + 10'd1;
    else                              v_cnt_d = v_cnt_q;

    if (vs_edge)                               vs_w_d = 10'(hs_edge);
    else if (hs_edge && vs_q && vs_w_q != '1)  vs_w_d = vs_w_q + 10'd1;
    else                                       vs_w_d = vs_w_q;

    bad_seen_d = vs_edge ? 1'b0 : (bad_seen_q | line_bad);

    case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d = SYNCING;
          good_d  = '0;
        end
      end
      SYNCING: begin
        if (line_bad) begin
          h_err_d = 1'b1;
          good_d  = '0;
        end
        if (vs_edge) begin
          if (frame_good) begin
            if (good_q + 4'd1 == 4'(LOCK_FRAMES)) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d  = good_q + 4'd1;
            end
          end else begin
            good_d = '0;
            if (!vtime_good) v_err_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (vs_edge) begin
          if (frame_good) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else if (!vtime_good) begin
            v_err_d = 1'b1;
            state_d = SEARCH;
          end
        end
        if (line_bad) begin
          h_err_d = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase

    in_win   = (h_cnt_d >= 11'(H_OFF)) && (h_cnt_d <= 11'(H_END)) &&
               (v_cnt_d >= 10'(V_OFF)) && (v_cnt_d <= 10'(V_END));
    locked_d = (state_d == LOCKED);
    px_de_d  = locked_d && in_win;
    px_x_d   = px_de_d ? 10'(h_cnt_d - 11'(H_OFF)) : 10'd0;
    px_y_d   = px_de_d ? (v_cnt_d - 10'(V_OFF)) : 10'd0;
    px_rgb_d = px_de_d ? rgb_q : 12'd0;
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      clr_q       <= 1'b0;
      rgb_q       <= '0;
      h_cnt_q     <= '0;
      hs_w_q      <= '0;
      v_cnt_q     <= '0;
      vs_w_q      <= '0;
      bad_seen_q  <= 1'b0;
      good_q      <= '0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
      locked_q    <= 1'b0;
      frame_cnt_q <= '0;
      px_x_q      <= '0;
      px_y_q      <= '0;
      px_de_q     <= 1'b0;
      px_rgb_q    <= '0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      hs_prev_q   <= hs_prev_d;
      vs_prev_q   <= vs_prev_d;
      clr_q       <= clr_d;
      rgb_q       <= rgb_d;
      h_cnt_q     <= h_cnt_d;
      hs_w_q      <= hs_w_d;
      v_cnt_q     <= v_cnt_d;
      vs_w_q      <= vs_w_d;
      bad_seen_q  <= bad_seen_d;
      good_q      <= good_d;
      h_err_q     <= h_err_d;
      v_err_q     <= v_err_d;
      locked_q    <= locked_d;
      frame_cnt_q <= frame_cnt_d;
      px_x_q      <= px_x_d;
      px_y_q      <= px_y_d;
      px_de_q     <= px_de_d;
      px_rgb_q    <= px_rgb_d;
    end
  end

  assign px_x      = px_x_q;
  assign px_y      = px_y_q;
  assign px_de     = px_de_q;
  assign px_rgb    = px_rgb_q;
  assign locked    = locked_q;
  assign h_err     = h_err_q;
  assign v_err     = v_err_q;
  assign frame_cnt = frame_cnt_q;

`ifdef VGA_SYNC_MONITOR_CHECKSUM_EN
  logic [15:0] sum_acc_q, sum_acc_d, frame_sum_q, frame_sum_d;
  logic        frame_sum_vld_q, frame_sum_vld_d;

  // Accumulate visible pixels; publish and restart the sum at each frame start.
  always_comb begin
    sum_acc_d       = sum_acc_q + (px_de_q ? 16'(px_rgb_q) : 16'd0);
    frame_sum_d     = frame_sum_q;
    frame_sum_vld_d = 1'b0;
    if (vs_edge) begin
      if (state_q == LOCKED) begin
        frame_sum_d     = sum_acc_d;
        frame_sum_vld_d = 1'b1;
      end
      sum_acc_d = '0;
    end
  end

  // Checksum registers.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      sum_acc_q       <= '0;
      frame_sum_q     <= '0;
      frame_sum_vld_q <= 1'b0;
    end else begin
      sum_acc_q       <= sum_acc_d;
      frame_sum_q     <= frame_sum_d;
      frame_sum_vld_q <= frame_sum_vld_d;
    end
  end

  assign frame_sum     = frame_sum_q;
  assign frame_sum_vld = frame_sum_vld_q;
`endif

endmodule
